// File: rtl/vector_mem_pkg.sv
// Shared types and helpers for the multi-lane vector memory and its stream engine.
package vector_mem_pkg;

  // Upper bounds for the lane-merge helper; word width must not exceed MAX_W.
  localparam int unsigned MAX_W     = 2048;
  localparam int unsigned MAX_UNITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } str_state_e;

  function automatic int unsigned word_width(input int unsigned ew, input int unsigned n);
    return ew * n;
  endfunction

  // Replace the lanes selected by mask with new_w, keep the rest from old_w.
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0]     old_w,
                                                  input logic [MAX_W-1:0]     new_w,
                                                  input logic [MAX_UNITS-1:0] mask,
                                                  input int unsigned          ew,
                                                  input int unsigned          n);
    logic [MAX_W-1:0]     lane_ones;
    logic [MAX_W-1:0]     bits;
    logic [MAX_UNITS-1:0] m;
    lane_ones = (MAX_W'(1) << ew) - MAX_W'(1);
    bits      = '0;
    for (int unsigned i = 0; i < n; i++) begin
      m = mask >> i;
      if (m[0]) bits = bits | (lane_ones << (i * ew));
    end
    return (old_w & ~bits) | (new_w & bits);
  endfunction

endpackage

// File: rtl/vector_mem_stream_fifo.sv
// Two-entry valid/ready FIFO whose head is a register, so outputs come straight from flops.
module stream_skid_fifo #(
  parameter int unsigned DW = 513
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_data_o,
  output logic          head_valid_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] head_q, head_d, tail_q, tail_d;
  logic          head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic [1:0]    count_q, count_d;
  logic          pop_c;

  assign pop_c        = pop_i & head_v_q;
  assign head_data_o  = head_q;
  assign head_valid_o = head_v_q;
  assign count_o      = count_q;

  // Upstream never pushes into a full FIFO.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    head_v_d = head_v_q;
    tail_v_d = tail_v_q;
    if (pop_c) begin
      if (tail_v_q) begin
        head_d = tail_q;
        if (push_i) tail_d = push_data_i;
        else        tail_v_d = 1'b0;
      end else if (push_i) begin
        head_d = push_data_i;
      end else begin
        head_d   = '0;
        head_v_d = 1'b0;
      end
    end else if (push_i) begin
      if (!head_v_q) begin
        head_d   = push_data_i;
        head_v_d = 1'b1;
      end else begin
        tail_d   = push_data_i;
        tail_v_d = 1'b1;
      end
    end
    count_d = count_q + 2'(push_i) - 2'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
      count_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      head_v_q <= head_v_d;
      tail_v_q <= tail_v_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vector_mem_stream.sv
// Multi-lane vector memory with masked write, registered random read and a burst readback engine.
module vector_mem_stream
  import vector_mem_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH = 64,
  parameter int unsigned NO_OF_UNITS   = 8,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DEPTH         = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [NO_OF_UNITS-1:0]               wr_mask,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] wr_data,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data,
  output logic                                 rd_valid,
  input  logic                                 str_start,
  input  logic [ADDR_WIDTH-1:0]                str_base,
  input  logic [ADDR_WIDTH:0]                  str_len,
  output logic                                 str_busy,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] str_data,
  output logic                                 str_valid,
  input  logic                                 str_ready,
  output logic                                 str_last,
  output logic                                 str_done
);

  localparam int unsigned W  = word_width(ELEMENT_WIDTH, NO_OF_UNITS);
  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = LW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [W-1:0] mem_q [DEPTH];

  str_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, issued_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [W-1:0]          rd_data_q;
  logic                  rd_valid_q, busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] rsel_addr_c;
  logic [W-1:0]          rword_c;
  logic                  issue_c, last_c, pop_c;
  logic [W:0]            fifo_head;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic [W-1:0] merge_w(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                           input logic [NO_OF_UNITS-1:0] mask);
    return W'(lane_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_UNITS'(mask), ELEMENT_WIDTH, NO_OF_UNITS));
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr)) mem_q[wr_addr] <= merge_w(mem_q[wr_addr], wr_data, wr_mask);
  end

  // Single read port: random read wins, same-cycle write is bypassed into the result.
  always_comb begin
    rsel_addr_c = rd_en ? rd_addr : addr_q;
    rword_c     = '0;
    if (in_range(rsel_addr_c)) begin
      rword_c = mem_q[rsel_addr_c];
      if (wr_en && (wr_addr == rsel_addr_c)) rword_c = merge_w(rword_c, wr_data, wr_mask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // RUN leaves on the cycle of the final issue so the last beat is always handshaken in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (str_start) state_d = (str_len != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (issue_c && last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (pop_c && fifo_head[W]) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_c  = (issued_q + LW'(1)) == len_q;
    issue_c = (state_q == ST_RUN) && !rd_en && (fifo_count < 2'd2) && (issued_q != len_q);
    pop_c   = fifo_valid && str_ready;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (rd_en) rd_data_q <= rword_c;
      if (state_q == ST_IDLE && str_start) begin
        len_q    <= str_len;
        issued_q <= '0;
        addr_q   <= ADDR_WIDTH'(32'(str_base) % DEPTH);
      end else if (issue_c) begin
        issued_q <= issued_q + LW'(1);
        addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  stream_skid_fifo #(.DW(W + 1)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (issue_c),
    .push_data_i  ({last_c, rword_c}),
    .pop_i        (str_ready),
    .head_data_o  (fifo_head),
    .head_valid_o (fifo_valid),
    .count_o      (fifo_count)
  );

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign str_busy  = busy_q;
  assign str_done  = done_q;
  assign str_data  = fifo_head[W-1:0];
  assign str_last  = fifo_head[W];
  assign str_valid = fifo_valid;

endmodule

// File: tb/tb_vector_mem_stream.sv
// Directed bench for vector_mem_stream with a word-level memory/stream model checked every cycle.
module tb_vector_mem_stream;

  localparam int EW = 64;
  localparam int NU = 8;
  localparam int AW = 10;
  localparam int D  = 1000;
  localparam int W  = EW * NU;

  logic          clk, rst;
  logic          wr_en, rd_en, str_start, str_ready;
  logic [AW-1:0] wr_addr, rd_addr, str_base;
  logic [NU-1:0] wr_mask;
  logic [W-1:0]  wr_data;
  logic [AW:0]   str_len;
  logic [W-1:0]  rd_data, str_data;
  logic          rd_valid, str_busy, str_valid, str_last, str_done;

  vector_mem_stream dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .str_start(str_start), .str_base(str_base), .str_len(str_len), .str_busy(str_busy),
    .str_data(str_data), .str_valid(str_valid), .str_ready(str_ready), .str_last(str_last),
    .str_done(str_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  logic [W-1:0] mem_m   [D];
  logic [W-1:0] exp_mem [1024];
  logic [W-1:0] cap     [16];
  logic [W-1:0] m_rd;
  logic         m_rv, m_done, m_busy;
  logic [AW:0]  m_len;
  logic         hs_last, hold;
  int           k;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [EW-1:0] v);
    return {NU{v}};
  endfunction

  // Word value seen by a read at address a this cycle, including a same-cycle write.
  function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    if (int'(a) >= D) return '0;
    v = mem_m[a];
    if (wr_en && wr_addr == a)
      for (int i = 0; i < NU; i++) if (wr_mask[i]) v[i*EW +: EW] = wr_data[i*EW +: EW];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rv   <= 1'b0;
      m_rd   <= '0;
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_len  <= '0;
    end else begin
      m_rv <= rd_en;
      if (rd_en) m_rd <= model_read(rd_addr);
      m_done <= hs_last || (str_start && !m_busy && str_len == '0);
      if (!m_busy && str_start) begin
        m_busy <= 1'b1;
        m_len  <= str_len;
        for (int j = 0; j < int'(str_len); j++) exp_mem[j] = mem_m[(int'(str_base) % D + j) % D];
      end else if (m_done) begin
        m_busy <= 1'b0;
      end
      if (wr_en && int'(wr_addr) < D)
        for (int i = 0; i < NU; i++) if (wr_mask[i]) mem_m[wr_addr][i*EW +: EW] = wr_data[i*EW +: EW];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [NU-1:0] m, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready toggles every cycle; 2: three rd_en steals plus an ignored start.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                           output int t_first, output int t_done);
    t_first = -1;
    t_done  = -1;
    str_ready = 1'b1; str_base = b; str_len = l; str_start = 1'b1;
    tick();
    str_start = 1'b0;
    for (int it = 0; it < 200; it++) begin
      if (str_valid && t_first < 0) t_first = it;
      if (str_done) t_done = it;
      if (!str_busy) break;
      if (mode == 1) str_ready = ~str_ready;
      rd_en     = (mode == 2) && (it == 1 || it == 3 || it == 5);
      rd_addr   = (it == 1) ? AW'(3) : (it == 3) ? AW'(999) : AW'(1023);
      str_start = (mode == 2) && (it == 2);
      str_base  = '0;
      str_len   = (AW+1)'(5);
      tick();
    end
    rd_en = 1'b0; str_start = 1'b0; str_ready = 1'b1;
    chk1("burst_ended", str_busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tf, td, tf2, td2;
    logic [W-1:0] v;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; str_start = 1'b0; str_ready = 1'b1;
    wr_addr = '0; rd_addr = '0; str_base = '0; str_len = '0; wr_mask = '0; wr_data = '0;
    k = 0; hold = 1'b0; hs_last = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          k = 0; hold = 1'b0; hs_last = 1'b0;
        end else begin
          hs_last = 1'b0;
          chk1("rd_valid", rd_valid, m_rv);
          chk("rd_data", rd_data, m_rd);
          chk1("str_done", str_done, m_done);
          chk1("str_busy", str_busy, m_busy);
          if (hold) chk1("str_valid_hold", str_valid, 1'b1);
          if (str_start && !m_busy) k = 0;
          if (str_valid) begin
            if (k >= int'(m_len)) chk1("str_extra_beat", str_valid, 1'b0);
            else begin
              chk("str_data", str_data, exp_mem[k]);
              chk1("str_last", str_last, k == int'(m_len) - 1);
              if (str_ready) begin
                if (k < 16) cap[k] = str_data;
                if (k == int'(m_len) - 1) hs_last = 1'b1;
                k++;
              end
            end
          end
          hold = str_valid && !str_ready;
        end
      end
    join_none

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, '0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_str_data", str_data, '0);
    chk1("rst_str_valid", str_valid, 1'b0);
    chk1("rst_str_last", str_last, 1'b0);
    chk1("rst_str_done", str_done, 1'b0);
    chk1("rst_str_busy", str_busy, 1'b0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < D; a++) do_write(AW'(a), '1, rep(EW'(a + 1)));

    for (int i = 0; i < NU; i++) v[i*EW +: EW] = EW'(i + 1);
    do_write(AW'(5), 8'hFF, v);
    do_read(AW'(5));
    chk1("t1_rd_valid", rd_valid, 1'b1);
    chk("t1_rd_data", rd_data, v);

    do_write(AW'(5), 8'h0F, rep(EW'(8'hAA)));
    do_read(AW'(5));
    for (int i = 0; i < NU; i++) v[i*EW +: EW] = (i < 4) ? EW'(8'hAA) : EW'(i + 1);
    chk("t2_rd_data", rd_data, v);

    do_write(AW'(9), 8'hFF, '0);
    wr_en = 1'b1; wr_addr = AW'(9); wr_mask = 8'h01; wr_data = W'(64'h33);
    rd_en = 1'b1; rd_addr = AW'(9);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t3_bypass", rd_data, W'(64'h33));
    tick();
    chk1("t3_no_req_valid", rd_valid, 1'b0);
    chk("t3_hold_data", rd_data, W'(64'h33));

    do_write(AW'(1000), 8'hFF, '1);
    do_read(AW'(1000));
    chk("oor_read", rd_data, '0);
    do_read(AW'(0));
    chk("addr0_read", rd_data, rep(EW'(1)));

    run_burst(AW'(D - 2), (AW+1)'(4), 1, tf, td);
    chk("wrap_beat0", cap[0], rep(EW'(999)));
    chk("wrap_beat1", cap[1], rep(EW'(1000)));
    chk("wrap_beat2", cap[2], rep(EW'(1)));
    chk("wrap_beat3", cap[3], rep(EW'(2)));

    run_burst(AW'(100), (AW+1)'(8), 0, tf, td);
    chk_int("throughput", td - tf, 8);
    chk("plain_beat7", cap[7], rep(EW'(108)));
    run_burst(AW'(100), (AW+1)'(8), 2, tf2, td2);
    chk_int("stall_delay", td2 - td, 3);
    chk("stall_beat4", cap[4], rep(EW'(105)));

    run_burst(AW'(0), '0, 0, tf, td);
    chk_int("len0_done_cycle", td, 0);
    chk_int("len0_no_valid", tf, -1);

    str_ready = 1'b1; str_base = AW'(50); str_len = (AW+1)'(10); str_start = 1'b1;
    tick();
    str_start = 1'b0;
    for (int i = 0; i < 50 && k < 3; i++) tick();
    chk_int("reset_reached_beat3", k, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_data", rd_data, '0);
    chk1("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_str_data", str_data, '0);
    chk1("mid_rst_str_valid", str_valid, 1'b0);
    chk1("mid_rst_str_last", str_last, 1'b0);
    chk1("mid_rst_str_done", str_done, 1'b0);
    chk1("mid_rst_str_busy", str_busy, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("post_rst_no_done", str_done, 1'b0);
    end
    run_burst(AW'(10), (AW+1)'(3), 0, tf, td);
    chk("post_rst_beat0", cap[0], rep(EW'(11)));
    chk("post_rst_beat2", cap[2], rep(EW'(13)));

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
